// File: rtl/fetch_fifo_writer.sv
// Producer side of the instruction prefetch FIFO: issues sequential fetches under a credit
// limit, writes in-order responses into the FIFO, and flushes/discards in-flight data on a jump.
module fetch_fifo_writer #(
  parameter int                      C_FIFO_DEPTH_X = 2,
  parameter int                      C_OUTST_X      = 1,
  parameter int                      C_ADDR_WIDTH   = 32,
  parameter int                      C_DATA_WIDTH   = 32,
  parameter logic [C_ADDR_WIDTH-1:0] C_RESET_VECTOR = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clk_en_i,
  input  logic                    jump_i,
  input  logic [C_ADDR_WIDTH-1:0] jump_addr_i,
  output logic                    ireq_valid_o,
  output logic [C_ADDR_WIDTH-1:0] ireq_addr_o,
  input  logic                    ireq_ready_i,
  input  logic                    irsp_valid_i,
  input  logic [C_DATA_WIDTH-1:0] irsp_data_i,
  output logic                    fifo_flush_o,
  output logic                    fifo_wr_o,
  output logic [C_DATA_WIDTH-1:0] fifo_data_o,
  output logic [C_ADDR_WIDTH-1:0] fifo_addr_o,
  input  logic                    fifo_rd_i
);

  localparam int OCC_W = C_FIFO_DEPTH_X + 1;
  localparam int OUT_W = C_OUTST_X + 1;
  localparam int SUM_W = ((OCC_W > OUT_W) ? OCC_W : OUT_W) + 1;
  localparam logic [C_ADDR_WIDTH-1:0] STEP       = C_ADDR_WIDTH'(C_DATA_WIDTH / 8);
  localparam logic [SUM_W-1:0]        FIFO_DEPTH = SUM_W'(2 ** C_FIFO_DEPTH_X);
  localparam logic [OUT_W-1:0]        OUTST_MAX  = OUT_W'(2 ** C_OUTST_X);

  logic [C_ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [C_ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [OUT_W-1:0]        outst_q, outst_d;
  logic [OUT_W-1:0]        drop_q, drop_d;

  logic [SUM_W-1:0] credit_sum;
  logic             credit_ok;
  logic             active;
  logic             accept;
  logic             rsp;
  logic             drop_nz;
  logic             rd_eff;

  // Credit counts only registered occupancy: a same-cycle FIFO read frees space next cycle.
  assign credit_sum   = SUM_W'(occ_q) + SUM_W'(outst_q);
  assign credit_ok    = (credit_sum < FIFO_DEPTH) && (outst_q < OUTST_MAX);
  assign active       = clk_en_i & ~reset_i;
  assign drop_nz      = (drop_q != '0);

  assign ireq_valid_o = active & ~jump_i & credit_ok;
  assign ireq_addr_o  = req_pc_q;
  assign accept       = ireq_valid_o & ireq_ready_i;
  assign rsp          = active & irsp_valid_i;
  assign fifo_wr_o    = rsp & ~drop_nz & ~jump_i;
  assign fifo_flush_o = active & jump_i;
  assign fifo_data_o  = irsp_data_i;
  assign fifo_addr_o  = rsp_pc_q;
  assign rd_eff       = active & fifo_rd_i & (occ_q != '0);

  always_comb begin
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    occ_d    = occ_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    if (clk_en_i) begin
      outst_d = outst_q + OUT_W'(accept) - OUT_W'(rsp);
      if (jump_i) begin
        // Everything still on the bus belongs to the old stream; the response arriving now is
        // already discarded, so it is not counted again.
        req_pc_d = jump_addr_i;
        rsp_pc_d = jump_addr_i;
        occ_d    = '0;
        drop_d   = outst_q - OUT_W'(irsp_valid_i);
      end else begin
        if (accept)
          req_pc_d = req_pc_q + STEP;
        if (fifo_wr_o)
          rsp_pc_d = rsp_pc_q + STEP;
        if (rsp && drop_nz)
          drop_d = drop_q - OUT_W'(1);
        occ_d = occ_q + OCC_W'(fifo_wr_o) - OCC_W'(rd_eff);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      req_pc_q <= C_RESET_VECTOR;
      rsp_pc_q <= C_RESET_VECTOR;
      occ_q    <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  a_occ_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    SUM_W'(occ_q) <= FIFO_DEPTH);
  a_credit_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    credit_sum <= FIFO_DEPTH);
  a_drop_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    drop_q <= outst_q);
  a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (reset_i)
    (clk_en_i && irsp_valid_i) |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_fifo_writer.sv
// Directed bench for fetch_fifo_writer: fill, credit release, jumps, address wrap and clock enable.
module tb_fetch_fifo_writer;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        clk_en_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        ireq_valid_o;
  logic [31:0] ireq_addr_o;
  logic        ireq_ready_i = 1'b0;
  logic        irsp_valid_i = 1'b0;
  logic [31:0] irsp_data_i = '0;
  logic        fifo_flush_o;
  logic        fifo_wr_o;
  logic [31:0] fifo_data_o;
  logic [31:0] fifo_addr_o;
  logic        fifo_rd_i = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_fifo_writer dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .clk_en_i    (clk_en_i),
    .jump_i      (jump_i),
    .jump_addr_i (jump_addr_i),
    .ireq_valid_o(ireq_valid_o),
    .ireq_addr_o (ireq_addr_o),
    .ireq_ready_i(ireq_ready_i),
    .irsp_valid_i(irsp_valid_i),
    .irsp_data_i (irsp_data_i),
    .fifo_flush_o(fifo_flush_o),
    .fifo_wr_o   (fifo_wr_o),
    .fifo_data_o (fifo_data_o),
    .fifo_addr_o (fifo_addr_o),
    .fifo_rd_i   (fifo_rd_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clk_en_i     = 1'b1;
    jump_i       = 1'b0;
    jump_addr_i  = '0;
    ireq_ready_i = 1'b0;
    irsp_valid_i = 1'b0;
    irsp_data_i  = '0;
    fifo_rd_i    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    next_cycle();
    reset_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    ireq_ready_i = 1'b1;
    jump_i = 1'b1;
    jump_addr_i = 32'h40;
    #1;
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ireq_valid_o); end
    checks++; if (fifo_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b want 0", fifo_wr_o); end
    checks++; if (fifo_flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", fifo_flush_o); end
    checks++; if (ireq_addr_o !== 32'h0) begin errors++; $display("FAIL reset_req_addr got %h want 0", ireq_addr_o); end
    checks++; if (fifo_addr_o !== 32'h0) begin errors++; $display("FAIL reset_fifo_addr got %h want 0", fifo_addr_o); end
    next_cycle();
    jump_i = 1'b0;
    ireq_ready_i = 1'b0;
    reset_i = 1'b0;
    #1;
    checks++; if (ireq_valid_o !== 1'b1) begin errors++; $display("FAIL post_reset_valid got %b want 1", ireq_valid_o); end
    checks++; if (ireq_addr_o !== 32'h0) begin errors++; $display("FAIL post_reset_addr got %h want 0", ireq_addr_o); end
  endtask

  // Ready always high, each response one cycle after its request, no consumer reads.
  task automatic test_fill();
    logic        exp_wr;
    logic        exp_valid;
    logic [31:0] exp_data;
    do_reset();
    ireq_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_wr    = (i >= 1) && (i <= 4);
      exp_valid = (i < 4);
      exp_data  = 32'hA000_0000 + 32'(i);
      irsp_valid_i = exp_wr;
      irsp_data_i  = exp_data;
      #1;
      checks++; if (ireq_valid_o !== exp_valid) begin errors++; $display("FAIL fill_valid[%0d] got %b want %b", i, ireq_valid_o, exp_valid); end
      if (exp_valid) begin
        checks++; if (ireq_addr_o !== 32'(4 * i)) begin errors++; $display("FAIL fill_req_addr[%0d] got %h want %h", i, ireq_addr_o, 32'(4 * i)); end
      end
      checks++; if (fifo_wr_o !== exp_wr) begin errors++; $display("FAIL fill_wr[%0d] got %b want %b", i, fifo_wr_o, exp_wr); end
      if (exp_wr) begin
        checks++; if (fifo_addr_o !== 32'(4 * (i - 1))) begin errors++; $display("FAIL fill_fifo_addr[%0d] got %h want %h", i, fifo_addr_o, 32'(4 * (i - 1))); end
        checks++; if (fifo_data_o !== exp_data) begin errors++; $display("FAIL fill_fifo_data[%0d] got %h want %h", i, fifo_data_o, exp_data); end
      end
      next_cycle();
    end
    irsp_valid_i = 1'b0;
  endtask

  // Continues from the full FIFO left by test_fill (occ=4, next address 0x10).
  task automatic test_full_read();
    ireq_ready_i = 1'b1;
    fifo_rd_i = 1'b1;
    #1;
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL rd_same_cycle_valid got %b want 0", ireq_valid_o); end
    next_cycle();
    fifo_rd_i = 1'b0;
    #1;
    checks++; if (ireq_valid_o !== 1'b1) begin errors++; $display("FAIL rd_next_valid got %b want 1", ireq_valid_o); end
    checks++; if (ireq_addr_o !== 32'h10) begin errors++; $display("FAIL rd_next_addr got %h want 00000010", ireq_addr_o); end
    next_cycle();
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'h5555_0010;
    #1;
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL rd_only_one_valid got %b want 0", ireq_valid_o); end
    checks++; if (fifo_wr_o !== 1'b1) begin errors++; $display("FAIL rd_refill_wr got %b want 1", fifo_wr_o); end
    checks++; if (fifo_addr_o !== 32'h10) begin errors++; $display("FAIL rd_refill_addr got %h want 00000010", fifo_addr_o); end
    next_cycle();
    irsp_valid_i = 1'b0;
    #1;
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL rd_full_again_valid got %b want 0", ireq_valid_o); end
    ireq_ready_i = 1'b0;
  endtask

  task automatic test_jump_flush();
    do_reset();
    jump_i = 1'b1;
    jump_addr_i = 32'h10;
    ireq_ready_i = 1'b1;
    #1;
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL jf_first_flush got %b want 1", fifo_flush_o); end
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL jf_first_valid got %b want 0", ireq_valid_o); end
    next_cycle();
    jump_i = 1'b0;
    #1;
    checks++; if (ireq_addr_o !== 32'h10) begin errors++; $display("FAIL jf_req0_addr got %h want 00000010", ireq_addr_o); end
    next_cycle();
    #1;
    checks++; if (ireq_addr_o !== 32'h14 || ireq_valid_o !== 1'b1) begin errors++; $display("FAIL jf_req1 got %b/%h want 1/00000014", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    jump_i = 1'b1;
    jump_addr_i = 32'h100;
    #1;
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL jf_flush got %b want 1", fifo_flush_o); end
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL jf_jump_valid got %b want 0", ireq_valid_o); end
    next_cycle();
    jump_i = 1'b0;
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'hDEAD_0010;
    #1;
    checks++; if (fifo_wr_o !== 1'b0) begin errors++; $display("FAIL jf_discard0_wr got %b want 0", fifo_wr_o); end
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL jf_outst_full_valid got %b want 0", ireq_valid_o); end
    next_cycle();
    ireq_ready_i = 1'b0;
    irsp_data_i = 32'hDEAD_0014;
    #1;
    checks++; if (fifo_wr_o !== 1'b0) begin errors++; $display("FAIL jf_discard1_wr got %b want 0", fifo_wr_o); end
    checks++; if (ireq_addr_o !== 32'h100 || ireq_valid_o !== 1'b1) begin errors++; $display("FAIL jf_new_req got %b/%h want 1/00000100", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    irsp_valid_i = 1'b0;
    ireq_ready_i = 1'b1;
    #1;
    checks++; if (ireq_addr_o !== 32'h100 || ireq_valid_o !== 1'b1) begin errors++; $display("FAIL jf_new_req_acc got %b/%h want 1/00000100", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    ireq_ready_i = 1'b0;
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'hCAFE_0100;
    #1;
    checks++; if (fifo_wr_o !== 1'b1) begin errors++; $display("FAIL jf_first_write got %b want 1", fifo_wr_o); end
    checks++; if (fifo_addr_o !== 32'h100) begin errors++; $display("FAIL jf_first_write_addr got %h want 00000100", fifo_addr_o); end
    checks++; if (fifo_data_o !== 32'hCAFE_0100) begin errors++; $display("FAIL jf_first_write_data got %h want cafe0100", fifo_data_o); end
    next_cycle();
    irsp_valid_i = 1'b0;
  endtask

  task automatic test_jump_with_rsp();
    do_reset();
    ireq_ready_i = 1'b1;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'h0) begin errors++; $display("FAIL jr_req got %b/%h want 1/00000000", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    jump_i = 1'b1;
    jump_addr_i = 32'h200;
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'hBAD0_0000;
    #1;
    checks++; if (fifo_wr_o !== 1'b0) begin errors++; $display("FAIL jr_discard_wr got %b want 0", fifo_wr_o); end
    checks++; if (fifo_flush_o !== 1'b1) begin errors++; $display("FAIL jr_flush got %b want 1", fifo_flush_o); end
    checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL jr_jump_valid got %b want 0", ireq_valid_o); end
    next_cycle();
    jump_i = 1'b0;
    irsp_valid_i = 1'b0;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'h200) begin errors++; $display("FAIL jr_next_req got %b/%h want 1/00000200", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    ireq_ready_i = 1'b0;
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'h0000_200D;
    #1;
    checks++; if (fifo_wr_o !== 1'b1) begin errors++; $display("FAIL jr_no_drop_wr got %b want 1", fifo_wr_o); end
    checks++; if (fifo_addr_o !== 32'h200) begin errors++; $display("FAIL jr_write_addr got %h want 00000200", fifo_addr_o); end
    next_cycle();
    irsp_valid_i = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    jump_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    next_cycle();
    jump_i = 1'b0;
    ireq_ready_i = 1'b1;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last got %b/%h want 1/fffffffc", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    ireq_ready_i = 1'b0;
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'h1234_5678;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next got %b/%h want 1/00000000", ireq_valid_o, ireq_addr_o); end
    checks++; if (fifo_wr_o !== 1'b1 || fifo_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_write got %b/%h want 1/fffffffc", fifo_wr_o, fifo_addr_o); end
    next_cycle();
    irsp_valid_i = 1'b0;
  endtask

  task automatic test_clk_en();
    do_reset();
    ireq_ready_i = 1'b1;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'h0) begin errors++; $display("FAIL ce_req got %b/%h want 1/00000000", ireq_valid_o, ireq_addr_o); end
    next_cycle();
    clk_en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      jump_i = (i == 1);
      jump_addr_i = 32'h300;
      fifo_rd_i = (i == 2);
      #1;
      checks++; if (ireq_valid_o !== 1'b0) begin errors++; $display("FAIL ce_off_valid[%0d] got %b want 0", i, ireq_valid_o); end
      checks++; if (fifo_wr_o !== 1'b0) begin errors++; $display("FAIL ce_off_wr[%0d] got %b want 0", i, fifo_wr_o); end
      checks++; if (fifo_flush_o !== 1'b0) begin errors++; $display("FAIL ce_off_flush[%0d] got %b want 0", i, fifo_flush_o); end
      next_cycle();
    end
    clk_en_i = 1'b1;
    jump_i = 1'b0;
    fifo_rd_i = 1'b0;
    ireq_ready_i = 1'b0;
    irsp_valid_i = 1'b1;
    irsp_data_i = 32'h0000_0077;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'h4) begin errors++; $display("FAIL ce_resume_req got %b/%h want 1/00000004", ireq_valid_o, ireq_addr_o); end
    checks++; if (fifo_wr_o !== 1'b1 || fifo_addr_o !== 32'h0) begin errors++; $display("FAIL ce_resume_write got %b/%h want 1/00000000", fifo_wr_o, fifo_addr_o); end
    next_cycle();
    irsp_valid_i = 1'b0;
    fifo_rd_i = 1'b1;
    next_cycle();
    next_cycle();
    fifo_rd_i = 1'b0;
    #1;
    checks++; if (ireq_valid_o !== 1'b1 || ireq_addr_o !== 32'h4) begin errors++; $display("FAIL ce_rd_empty_ignored got %b/%h want 1/00000004", ireq_valid_o, ireq_addr_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_read();
    test_jump_flush();
    test_jump_with_rsp();
    test_wrap();
    test_clk_en();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
